// File: rtl/apb_master_pkg.sv
// Shared types and address-map constants for the APB master bridge.
`timescale 1ns/1ps
package apb_master_pkg;

  // Bridge sequencing states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } apb_state_t;

  // Slave index field inside the byte address
  localparam int unsigned IDX_LSB    = 12;
  localparam int unsigned IDX_MSB    = 15;
  localparam int unsigned IDX_W      = IDX_MSB - IDX_LSB + 1;

  // Peripheral region field compared against the base address
  localparam int unsigned REGION_LSB = 16;
  localparam int unsigned REGION_MSB = 31;
  localparam int unsigned REGION_W   = REGION_MSB - REGION_LSB + 1;

  // Region field of an address
  function automatic logic [REGION_W-1:0] region_of(input logic [31:0] a);
    return a[REGION_MSB:REGION_LSB];
  endfunction

  // Slave index field of an address
  function automatic logic [IDX_W-1:0] index_of(input logic [31:0] a);
    return a[IDX_MSB:IDX_LSB];
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: maps a byte address to a slave index and a
// hit flag (address in the peripheral region and index populated).
`timescale 1ns/1ps
module apb_addr_decoder
  import apb_master_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  localparam logic [IDX_W:0] SLAVE_COUNT = (IDX_W+1)'(NUM_SLAVES);

  // Byte offset within a slave window plays no part in decoding
  logic unused_offset;
  assign unused_offset = ^addr[IDX_LSB-1:0];

  // Region compare and populated-index check
  always_comb begin
    index = index_of(addr);
    hit   = (region_of(addr) == region_of(BASE_ADDR)) &&
            ({1'b0, index} < SLAVE_COUNT);
  end

endmodule

// File: rtl/apb_master.sv
// Single-initiator APB bridge: takes one CPU-side request at a time, runs an
// APB SETUP/ACCESS transfer to the decoded slave and returns a one-cycle
// completion pulse with read data and an error flag.
`timescale 1ns/1ps
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     transfer,
  input  logic                     write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic                     busy,
  output logic [31:0]              PADDR,
  output logic [31:0]              PWDATA,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [NUM_SLAVES*32-1:0] PRDATA_S,
  input  logic [NUM_SLAVES-1:0]    PREADY_S
);

  localparam int unsigned         CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_t              state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx_q;
  logic                    hit_q;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR)
  ) u_decoder (
    .addr  (addr),
    .hit   (dec_hit),
    .index (dec_idx)
  );

  // One-hot select pattern for the incoming request's index
  always_comb begin
    dec_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (dec_idx == IDX_W'(i)) begin
        dec_onehot[i] = 1'b1;
      end
    end
  end

  // Return-path mux: only the latched slave's PREADY/PRDATA are visible
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = PREADY_S[i];
        sel_rdata = PRDATA_S[i*32 +: 32];
      end
    end
  end

  // Transfer sequencer; PSEL/PENABLE/busy are registered alongside the state
  // (PSEL loaded on the IDLE->SETUP edge) so none depend combinationally on PREADY
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            PWRITE <= write;
            PADDR  <= addr;
            PWDATA <= wdata;
            idx_q  <= dec_idx;
            hit_q  <= dec_hit;
            PSEL   <= dec_hit ? dec_onehot : '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (hit_q) begin
            PENABLE <= 1'b1;
            state   <= ST_ACCESS;
          end else begin
            rdata <= '0;
            err   <= 1'b1;
            ready <= 1'b1;
            state <= ST_DONE;
          end
        end

        ST_ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (sel_ready) begin
            rdata   <= PWRITE ? '0 : sel_rdata;
            err     <= 1'b0;
            ready   <= 1'b1;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            rdata   <= '0;
            err     <= 1'b1;
            ready   <= 1'b1;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: stimulus pushes expected completions,
// an independent monitor pops and compares on every ready pulse.
`timescale 1ns/1ps
module tb_apb_master;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 8;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              transfer;
  logic              write;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic              busy;
  logic [31:0]       PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic              PENABLE;
  logic [NS-1:0]     PSEL;
  logic [NS*32-1:0]  PRDATA_S;
  logic [NS-1:0]     PREADY_S;

  apb_master #(
    .NUM_SLAVES (NS),
    .BASE_ADDR  (32'h1000_0000),
    .TIMEOUT    (TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .busy     (busy),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA_S (PRDATA_S),
    .PREADY_S (PREADY_S)
  );

  always #5 PCLK = ~PCLK;

  int unsigned cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int viol   = 0;

  // Slave models: each answers after wait_cyc[i] extra ACCESS cycles
  int          wait_cyc [NS];
  logic [31:0] rd_val   [NS];
  int          acc_cnt  = 0;
  logic        noise_en = 1'b0;
  logic        tog      = 1'b0;

  always @(posedge PCLK) begin
    acc_cnt <= PENABLE ? acc_cnt + 1 : 0;
    tog     <= ~tog;
  end

  always_comb begin
    PRDATA_S = '0;
    PREADY_S = '0;
    for (int i = 0; i < NS; i++) begin
      PRDATA_S[i*32 +: 32] = rd_val[i];
      PREADY_S[i] = (PSEL[i] && PENABLE && (acc_cnt == wait_cyc[i])) ||
                    (noise_en && tog && !PSEL[i]);
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int unsigned cy;
    string       nm;
  } exp_t;

  exp_t sb[$];

  function automatic void push_exp(input string nm, input logic [31:0] rd,
                                   input logic er, input int unsigned cy);
    exp_t e;
    e.nm = nm;
    e.rd = rd;
    e.er = er;
    e.cy = cy;
    sb.push_back(e);
  endfunction

  // Completion monitor
  always @(negedge PCLK) begin : mon
    exp_t e;
    if (!PRESET && ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected no completion", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_rdata"}, rdata, e.rd);
        chk({e.nm, "_err"}, 32'(err), 32'(e.er));
        chk({e.nm, "_cycle"}, cyc, e.cy);
      end
    end
  end

  // Select-line sanity: never more than one PSEL, never PENABLE without PSEL
  always @(negedge PCLK) begin
    if (!$onehot0(PSEL) || (PENABLE && PSEL == '0)) viol++;
  end

  task automatic wait_ready(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge PCLK);
      if (ready === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_no_ready: got no ready in 20 cycles expected a completion", nm);
    end
  endtask

  // Issue one request at a negedge and follow it through SETUP/ACCESS/DONE
  task automatic req(input string nm, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd,
                     input logic exp_er, input logic [NS-1:0] exp_sel,
                     input int n_acc);
    int unsigned c0;
    c0       = cyc;
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
    push_exp(nm, exp_rd, exp_er, c0 + 2 + int'(n_acc));
    @(negedge PCLK);
    transfer = 1'b0;
    chk({nm, "_setup_psel"}, 32'(PSEL), 32'(exp_sel));
    chk({nm, "_setup_penable"}, 32'(PENABLE), 32'd0);
    chk({nm, "_setup_busy"}, 32'(busy), 32'd1);
    chk({nm, "_paddr"}, PADDR, a);
    chk({nm, "_pwrite"}, 32'(PWRITE), 32'(w));
    if (w) chk({nm, "_pwdata"}, PWDATA, d);
    for (int k = 0; k < n_acc; k++) begin
      @(negedge PCLK);
      chk({nm, "_access_psel"}, 32'(PSEL), 32'(exp_sel));
      chk({nm, "_access_penable"}, 32'(PENABLE), 32'd1);
    end
    wait_ready(nm);
    chk({nm, "_done_psel"}, 32'(PSEL), 32'd0);
    @(negedge PCLK);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_psel"}, 32'(PSEL), 32'd0);
    chk({nm, "_penable"}, 32'(PENABLE), 32'd0);
    chk({nm, "_ready"}, 32'(ready), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'd0);
    chk({nm, "_rdata"}, rdata, 32'd0);
    chk({nm, "_paddr"}, PADDR, 32'd0);
    chk({nm, "_pwdata"}, PWDATA, 32'd0);
    chk({nm, "_pwrite"}, 32'(PWRITE), 32'd0);
  endtask

  initial begin
    int unsigned c0;
    PRESET   = 1'b1;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    wait_cyc[0] = 0;   rd_val[0] = 32'hDEAD_0000;
    wait_cyc[1] = 255; rd_val[1] = 32'h1111_1111;
    wait_cyc[2] = 3;   rd_val[2] = 32'h0000_00A5;
    wait_cyc[3] = 1;   rd_val[3] = 32'h0000_0033;

    repeat (3) @(negedge PCLK);
    chk_reset_vals("reset");
    PRESET = 1'b0;
    @(negedge PCLK);

    req("wr_s0",           1'b1, 32'h1000_0000, 32'h0000_00FF, 32'h0, 1'b0, 4'b0001, 1);
    req("rd_s2_wait3",     1'b0, 32'h1000_2004, 32'h0,         32'hA5, 1'b0, 4'b0100, 4);
    req("rd_s3",           1'b0, 32'h1000_3010, 32'h0,         32'h33, 1'b0, 4'b1000, 2);
    req("unmapped_region", 1'b0, 32'h2000_0000, 32'h0,         32'h0, 1'b1, 4'b0000, 0);
    req("unmapped_index",  1'b0, 32'h1000_5000, 32'h0,         32'h0, 1'b1, 4'b0000, 0);

    noise_en = 1'b1;
    req("timeout_s1",      1'b0, 32'h1000_1000, 32'h0,         32'h0, 1'b1, 4'b0010, int'(TO));
    noise_en = 1'b0;

    wait_cyc[3] = int'(TO) - 1;
    req("ready_at_expiry", 1'b0, 32'h1000_3000, 32'h0,         32'h33, 1'b0, 4'b1000, int'(TO));

    // Back-to-back with transfer held high across the first completion
    c0       = cyc;
    transfer = 1'b1;
    write    = 1'b1;
    addr     = 32'h1000_0008;
    wdata    = 32'hCAFE_F00D;
    push_exp("b2b_wr", 32'h0, 1'b0, c0 + 3);
    push_exp("b2b_rd", 32'hDEAD_0000, 1'b0, c0 + 7);
    wait_ready("b2b_wr");
    write = 1'b0;
    addr  = 32'h1000_0004;
    wdata = '0;
    @(negedge PCLK);
    chk("b2b_gap_busy", 32'(busy), 32'd0);
    chk("b2b_gap_psel", 32'(PSEL), 32'd0);
    @(negedge PCLK);
    transfer = 1'b0;
    chk("b2b_rd_setup_psel", 32'(PSEL), 32'b0001);
    chk("b2b_rd_paddr", PADDR, 32'h1000_0004);
    chk("b2b_rd_pwrite", 32'(PWRITE), 32'd0);
    wait_ready("b2b_rd");
    @(negedge PCLK);

    // Reset while a transfer sits in ACCESS
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_1000;
    wdata    = 32'h5555_AAAA;
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    chk("abort_in_access", 32'(PENABLE), 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk_reset_vals("abort");
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("abort_no_ready", 32'(ready), 32'd0);

    req("after_reset",     1'b0, 32'h1000_2000, 32'h0,         32'hA5, 1'b0, 4'b0100, 4);

    repeat (2) @(negedge PCLK);
    chk("protocol_violations", 32'(viol), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-initiator APB bridge: accepts one word-sized read or write request at a time from the CPU-side data bus and runs a standard APB SETUP/ACCESS transfer toward the peripheral slaves, such as the GPIO peripheral. Decodes the address into one PSEL per slave, multiplexes the selected slave's PRDATA/PREADY back, and returns a one-cycle completion pulse with read data and an error flag. Sits between the core's load/store port and the peripheral slaves.

## Interface
Parameters:
- NUM_SLAVES, 4, number of PSEL lines / slave return ports (1..16)
- BASE_ADDR, 32'h1000_0000, peripheral region base; only bits [31:16] compared
- TIMEOUT, 255, ACCESS cycles allowed without PREADY before abort (>=1)

Ports:
- PCLK  in  1  clock; one clock domain, all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- transfer  in  1  request strobe, sampled only in IDLE
- write  in  1  1 = write, 0 = read
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  error qualifier, valid while ready=1
- busy  out  1  high in SETUP/ACCESS/DONE
- PADDR  out  32  APB address, full latched addr
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB enable
- PSEL  out  NUM_SLAVES  one-hot select
- PRDATA_S  in  NUM_SLAVES x 32  per-slave read data
- PREADY_S  in  NUM_SLAVES  per-slave ready

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: if transfer=1, latch write/addr/wdata into PWRITE/PADDR/PWDATA, compute select index = addr[15:12] and hit = (addr[31:16]==BASE_ADDR[31:16]) && (index < NUM_SLAVES); go SETUP. transfer while not IDLE is ignored (requester holds until ready).
- SETUP: PSEL[index]=hit, PENABLE=0. If hit go ACCESS, else go DONE with err=1, rdata=0 (no APB transfer; PSEL stays all-zero).
- ACCESS: PSEL[index]=1, PENABLE=1; timeout counter increments each cycle. If PREADY_S[index]=1: capture rdata=PRDATA_S[index] (reads) or 0 (writes), err=0, go DONE. Else if counter reaches TIMEOUT-1 with no PREADY: rdata=0, err=1, go DONE.
- DONE: ready=1 for exactly one cycle, PSEL=0, PENABLE=0; go IDLE.
- PADDR/PWDATA/PWRITE stable from SETUP through end of ACCESS; hold last value in IDLE/DONE.
- PRDATA_S/PREADY_S of unselected slaves never affect outputs.
- Counter cleared on entry to SETUP; width clog2(TIMEOUT+1).

## Timing
- Reset (synchronous): state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, ready=0, err=0, busy=0, counter=0.
- PSEL/PENABLE/busy decoded from state register only, glitch-free, no combinational path from PREADY_S.
- transfer at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2; PREADY seen in cycle 2+N -> ready pulse cycle 3+N; next transfer accepted in cycle 4+N (IDLE).
- Unmapped: transfer cycle 0 -> SETUP 1 -> DONE 2 (ready=1, err=1).
- Timeout: ready=1, err=1 in the cycle after the TIMEOUT-th ACCESS cycle.
- PREADY on the same cycle the counter expires: PREADY wins (err=0).
- PRESET mid-transfer: next edge returns to IDLE with all outputs at reset values; no ready pulse for the aborted request.

## Structure
- Package apb_master_pkg: state enum (IDLE, SETUP, ACCESS, DONE), address-field constants (index bits [15:12], region bits [31:16]).
- Sub-module apb_addr_decoder: combinational addr -> {hit, index}, reused by the memory-map checker.

## Test plan
- Write 0x0000_00FF to 0x1000_0000, slave 0 PREADY on first ACCESS cycle -> PSEL=4'b0001 SETUP then PENABLE, PWDATA=0xFF, ready at cycle 3, err=0.
- Read 0x1000_2004, slave 2 inserts 3 wait states returning 0xA5 -> PSEL=4'b0100 held 4 ACCESS cycles, rdata=0x0000_00A5 with ready at cycle 6.
- Read 0x2000_0000 (unmapped) and 0x1000_5000 (index >= NUM_SLAVES) -> PSEL never asserted, ready=1, err=1, rdata=0 at cycle 2.
- Slave 1 never asserts PREADY, TIMEOUT=8 -> 8 ACCESS cycles, then ready=1, err=1, rdata=0; unselected slaves' PREADY toggling ignored.
- Back-to-back: write 0x1000_0008 then read 0x1000_0004 with transfer held high -> second request starts only in IDLE after first ready; no overlap of PSEL.
- PRESET asserted in ACCESS -> next cycle IDLE, PSEL=0, PENABLE=0, ready=0; following request completes normally.
